// File: rtl/axis_fft_mirror_if.sv
// AXI-stream style bundle for complex spectrum bins: data, bin index, valid/ready.
interface axis_fft_mirror_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/axis_fft_mirror.sv
// Expands an N/2-bin half spectrum into the full N-bin Hermitian spectrum:
// pass-through of bins 0..N/2-1, zero Nyquist bin, then conjugates in mirrored order.
//
// state  | meaning
// PASS   | accept and forward input bins while storing them
// NYQ    | emit bin N/2 as zero, launch first mirror read
// MIRROR | emit conj(buffer[N-j]) for j = N/2+1..N-1
module axis_fft_mirror #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int AXIS_TUSER_WIDTH = 16,
    parameter int MAX_LOG_NFFT     = 12
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [3:0]        cfg_nfft,
    axis_fft_mirror_if.slave  s_axis,
    axis_fft_mirror_if.master m_axis
);
    localparam int W     = AXIS_TDATA_WIDTH;
    localparam int HW    = W / 2;
    localparam int CW    = MAX_LOG_NFFT + 1;
    localparam int AW    = MAX_LOG_NFFT - 1;
    localparam int DEPTH = 2 ** AW;
    localparam logic [3:0]    LOG_MIN = 4'd3;
    localparam logic [3:0]    LOG_MAX = 4'(MAX_LOG_NFFT);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {PASS, NYQ, MIRROR} state_t;

    state_t                      state, state_nxt;
    logic [CW-1:0]               cnt, cnt_nxt;
    logic [3:0]                  log_n, log_n_nxt;
    logic [3:0]                  cfg_clamped, log_eff;
    logic [CW-1:0]               half, n_full;
    logic                        out_valid, out_valid_nxt;
    logic [W-1:0]                out_data, out_data_nxt;
    logic [AXIS_TUSER_WIDTH-1:0] out_user, out_user_nxt;
    logic                        load_en, s_fire;
    logic                        wr_en, rd_en;
    logic [AW-1:0]               wr_addr, rd_addr;
    logic [W-1:0]                rd_data;
    logic [W-1:0]                mem [DEPTH];
    logic                        unused_tuser;

    function automatic logic [W-1:0] conj(input logic [W-1:0] d);
        logic [HW-1:0] im;
        im = d[W-1:HW];
        if (im == {1'b1, {(HW-1){1'b0}}})
            im = {1'b0, {(HW-1){1'b1}}};
        else
            im = -im;
        return {im, d[HW-1:0]};
    endfunction

    always_comb begin
        cfg_clamped = cfg_nfft;
        if (cfg_nfft < LOG_MIN)
            cfg_clamped = LOG_MIN;
        else if (cfg_nfft > LOG_MAX)
            cfg_clamped = LOG_MAX;
    end

    // The first beat of a frame must already see the new size.
    assign log_eff = (state == PASS && cnt == '0) ? cfg_clamped : log_n;
    assign half    = ONE << (log_eff - 4'd1);
    assign n_full  = ONE << log_eff;

    assign load_en       = !out_valid || m_axis.tready;
    assign s_axis.tready = !areset && (state == PASS) && load_en;
    assign s_fire        = s_axis.tvalid && s_axis.tready;
    assign unused_tuser  = ^s_axis.tuser;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        log_n_nxt     = log_n;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_user_nxt  = out_user;
        wr_en         = 1'b0;
        wr_addr       = cnt[AW-1:0];
        rd_en         = 1'b0;
        rd_addr       = '0;
        case (state)
            PASS: begin
                if (s_fire) begin
                    wr_en         = 1'b1;
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = s_axis.tdata;
                    out_user_nxt  = AXIS_TUSER_WIDTH'(cnt);
                    if (cnt == '0)
                        log_n_nxt = cfg_clamped;
                    if (cnt == half - ONE) begin
                        state_nxt = NYQ;
                        cnt_nxt   = half;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end else if (load_en) begin
                    out_valid_nxt = 1'b0;
                end
            end
            NYQ: begin
                if (load_en) begin
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = '0;
                    out_user_nxt  = AXIS_TUSER_WIDTH'(cnt);
                    rd_en         = 1'b1;
                    rd_addr       = AW'(cnt - ONE);
                    cnt_nxt       = cnt + ONE;
                    state_nxt     = MIRROR;
                end
            end
            MIRROR: begin
                if (load_en) begin
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = conj(rd_data);
                    out_user_nxt  = AXIS_TUSER_WIDTH'(cnt);
                    if (cnt == n_full - ONE) begin
                        state_nxt = PASS;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + ONE;
                        rd_en   = 1'b1;
                        rd_addr = AW'(n_full - cnt - ONE);
                    end
                end
            end
            default: state_nxt = PASS;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= PASS;
            cnt       <= '0;
            log_n     <= LOG_MIN;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_user  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            log_n     <= log_n_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_user  <= out_user_nxt;
        end
    end

    // rd_data only updates on an advancing read, so it doubles as the skid
    // register holding the prefetched bin through output backpressure.
    always_ff @(posedge aclk) begin
        if (wr_en)
            mem[wr_addr] <= s_axis.tdata;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

    assign m_axis.tdata  = out_data;
    assign m_axis.tuser  = out_user;
    assign m_axis.tvalid = out_valid;
endmodule

// File: tb/tb_axis_fft_mirror.sv
// Self-checking bench for axis_fft_mirror: table vectors, corner sequences and
// random frames against a Hermitian-spectrum reference model.
`timescale 1ns/1ps
module tb_axis_fft_mirror;
    typedef struct {
        logic [15:0] in_re;
        logic [15:0] in_im;
        logic [15:0] exp_re;
        logic [15:0] exp_im;
    } vec_t;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic [3:0] cfg_nfft = 4'd3;

    axis_fft_mirror_if s_if ();
    axis_fft_mirror_if m_if ();

    axis_fft_mirror dut (
        .aclk     (aclk),
        .areset   (areset),
        .cfg_nfft (cfg_nfft),
        .s_axis   (s_if),
        .m_axis   (m_if)
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    logic [31:0] frame_q[$];
    logic [31:0] exp_data[$];
    logic [31:0] got_data[$];
    int          exp_user[$];
    int          got_user[$];
    int          got_cyc[$];
    int          cur_half = 4;
    int          s_cnt = 0;
    bit          tail = 0;
    int          tail_last = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic [15:0] prev_user = '0;
    vec_t        tbl[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] s16(input int v);
        return 16'(v);
    endfunction

    function automatic logic [31:0] conj_ref(input logic [31:0] d);
        int im;
        im = $signed(d[31:16]);
        im = -im;
        if (im > 32767) im = 32767;
        return {16'(im), d[15:0]};
    endfunction

    always @(posedge aclk) cyc++;

    initial begin
        int ph;
        ph = 0;
        m_if.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (ready_mode)
                0: m_if.tready = 1'b1;
                1: begin
                    m_if.tready = (ph == 0 || ph == 3);
                    ph = (ph + 1) % 4;
                end
                default: m_if.tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge aclk) begin
        if (areset) begin
            tail = 0;
            s_cnt = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_if.tvalid, 1);
                check("hold_data", m_if.tdata, prev_data);
                check("hold_user", m_if.tuser, prev_user);
            end
            if (tail) begin
                if (m_if.tvalid && m_if.tready && int'(m_if.tuser) == tail_last)
                    tail = 0;
                else
                    check("s_tready_tail", s_if.tready, 0);
            end
            if (s_if.tvalid && s_if.tready) begin
                if (s_cnt == cur_half - 1) begin
                    tail = 1;
                    tail_last = 2 * cur_half - 1;
                    s_cnt = 0;
                end else begin
                    s_cnt++;
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                got_data.push_back(m_if.tdata);
                got_user.push_back(int'(m_if.tuser));
                got_cyc.push_back(cyc);
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data = m_if.tdata;
            prev_user = m_if.tuser;
        end
    end

    // Builds the expected full spectrum from frame_q, then streams frame_q in.
    task automatic drive_frame(input logic [3:0] cfg, input int change_after, input logic [3:0] cfg2);
        int half, n, waited;
        half = frame_q.size();
        n = 2 * half;
        for (int j = 0; j < n; j++) begin
            exp_user.push_back(j);
            if (j < half)       exp_data.push_back(frame_q[j]);
            else if (j == half) exp_data.push_back(32'h0);
            else                exp_data.push_back(conj_ref(frame_q[n - j]));
        end
        @(posedge aclk);
        #1;
        cur_half = half;
        cfg_nfft = cfg;
        for (int k = 0; k < half; k++) begin
            s_if.tdata = frame_q[k];
            s_if.tuser = 16'(k);
            s_if.tvalid = 1'b1;
            waited = 0;
            @(negedge aclk);
            while (!s_if.tready && waited < 5000) begin
                waited++;
                @(negedge aclk);
            end
            if (!s_if.tready) begin
                n_checks++;
                n_fail++;
                $display("FAIL s_accept_timeout: beat %0d not accepted, required accept within 5000 cycles", k);
                s_if.tvalid = 1'b0;
                return;
            end
            @(posedge aclk);
            #1;
            if (k == change_after) cfg_nfft = cfg2;
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int waited;
        waited = 0;
        while (got_data.size() < exp_data.size() && waited < 40000) begin
            @(negedge aclk);
            waited++;
        end
        repeat (4) @(negedge aclk);
        check({name, "_count"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check({name, "_data"}, got_data[i], exp_data[i]);
            check({name, "_user"}, got_user[i], exp_user[i]);
        end
    endtask

    task automatic clear_q();
        got_data.delete();
        got_user.delete();
        got_cyc.delete();
        exp_data.delete();
        exp_user.delete();
    endtask

    task automatic load_table_frame();
        frame_q.delete();
        for (int i = 0; i < 4; i++) frame_q.push_back({tbl[i].in_im, tbl[i].in_re});
    endtask

    task automatic check_table(input string name);
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            check({name, "_tbl_data"}, got_data[i], {tbl[i].exp_im, tbl[i].exp_re});
            check({name, "_tbl_user"}, got_user[i], i);
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        tbl[0] = '{16'd1, 16'd0,   16'd1, 16'd0};
        tbl[1] = '{16'd2, 16'd3,   16'd2, 16'd3};
        tbl[2] = '{16'd4, s16(-5), 16'd4, s16(-5)};
        tbl[3] = '{16'd6, 16'd7,   16'd6, 16'd7};
        tbl[4] = '{16'd0, 16'd0,   16'd0, 16'd0};
        tbl[5] = '{16'd0, 16'd0,   16'd6, s16(-7)};
        tbl[6] = '{16'd0, 16'd0,   16'd4, 16'd5};
        tbl[7] = '{16'd0, 16'd0,   16'd2, s16(-3)};

        s_if.tdata = '0;
        s_if.tuser = '0;
        s_if.tvalid = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_m_tdata", m_if.tdata, 0);
        check("rst_m_tuser", m_if.tuser, 0);
        check("rst_s_tready", s_if.tready, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        s_if.tvalid = 1'b0;
        @(negedge aclk);
        check("idle_m_tvalid", m_if.tvalid, 0);

        // N=8 reference frame at full rate
        ready_mode = 0;
        load_table_frame();
        drive_frame(4'd3, -1, 4'd3);
        wait_out("basic");
        check_table("basic");
        for (int i = 1; i < 8 && i < got_cyc.size(); i++)
            check("basic_no_gap", got_cyc[i] - got_cyc[0], i);
        clear_q();

        // same frame with 1,0,0,1 backpressure
        ready_mode = 1;
        load_table_frame();
        drive_frame(4'd3, -1, 4'd3);
        wait_out("toggle");
        check_table("toggle");
        clear_q();
        ready_mode = 0;

        // saturating conjugate of the most negative imag
        frame_q.delete();
        frame_q.push_back({16'h0000, 16'h0001});
        frame_q.push_back({16'h8000, 16'h1234});
        frame_q.push_back({16'h0004, 16'h0003});
        frame_q.push_back({16'h0006, 16'h0005});
        drive_frame(4'd3, -1, 4'd3);
        wait_out("sat");
        if (got_data.size() > 7) check("sat_bin7", got_data[7], {16'h7FFF, 16'h1234});
        clear_q();

        // cfg change mid-frame is ignored; next frame picks it up
        frame_q.delete();
        for (int i = 0; i < 8; i++) frame_q.push_back($urandom());
        drive_frame(4'd4, 1, 4'd3);
        wait_out("cfgchg16");
        clear_q();
        frame_q.delete();
        for (int i = 0; i < 4; i++) frame_q.push_back($urandom());
        drive_frame(4'd3, -1, 4'd3);
        wait_out("cfgchg8");
        clear_q();

        // reset during MIRROR of an N=16 frame
        frame_q.delete();
        for (int i = 0; i < 8; i++) frame_q.push_back($urandom());
        drive_frame(4'd4, -1, 4'd4);
        waited = 0;
        @(negedge aclk);
        while (!(m_if.tvalid && int'(m_if.tuser) == 10) && waited < 200) begin
            waited++;
            @(negedge aclk);
        end
        check("mirror_reached", m_if.tuser, 10);
        @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("rst_mid_tvalid", m_if.tvalid, 0);
        clear_q();
        load_table_frame();
        drive_frame(4'd1, -1, 4'd1);
        wait_out("post_rst");
        check_table("post_rst");
        clear_q();

        // three back-to-back max-size random frames under random backpressure
        ready_mode = 2;
        for (int f = 0; f < 3; f++) begin
            frame_q.delete();
            for (int i = 0; i < 2048; i++) begin
                if ($urandom_range(0, 15) == 0)
                    frame_q.push_back({16'h8000, 16'($urandom())});
                else
                    frame_q.push_back($urandom());
            end
            drive_frame((f == 2) ? 4'd15 : 4'd12, -1, (f == 2) ? 4'd15 : 4'd12);
        end
        wait_out("rand");
        check("rand_total", got_data.size(), 3 * 4096);
        clear_q();
        ready_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
